usb_buffer_arbiter: RTL and testbench
=====================================

# usb_buffer_arbiter

Shares a single-port packet buffer RAM between the USB serial interface engine (SIE) and the J1 processor I/O bus inside `usb_device_controller`. The SIE streams received and transmitted packet bytes at low-speed byte rate. The J1 reads received data and loads transmit data through memory-mapped accesses. The block owns the RAM, arbitrates one access per clock, and gives the CPU a busy/wait handshake.

## Interface
- `DEPTH`, 64: buffer size in bytes, power of two; `AW = $clog2(DEPTH)`.
- `BASE_ADDR`, 16'h0100: I/O window base, aligned to DEPTH.
- `clk` in 1: system clock, 24 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `sie_req` in 1: SIE access request; held until acknowledged.
- `sie_we` in 1: 1 = write, 0 = read; stable while `sie_req`.
- `sie_addr` in AW: SIE byte address.
- `sie_wdata` in 8: SIE write data.
- `sie_ack` out 1: one-cycle grant acknowledge.
- `sie_rdata` out 8: read data, valid while `sie_ack`.
- `io_addr` in 16: J1 address.
- `io_dout` in 16: J1 write data; bits [7:0] are used.
- `io_rd` in 1: one-cycle read strobe.
- `io_wr` in 1: one-cycle write strobe.
- `io_rdata` out 8: CPU read result; holds until the next CPU read completes.
- `io_busy` out 1: CPU access pending.
- `io_err` out 1: sticky; set when a strobe hits the window while busy.

## Operation
- **Window decode:** `hit` = `(io_rd|io_wr) && io_addr[15:AW] == BASE_ADDR[15:AW]`. Offset is `io_addr[AW-1:0]`.
- **CPU capture:**
  - A hit with `io_busy`=0 latches op, offset and `io_dout[7:0]` into the pending register; `cpu_pend`←1.
  - A hit with `io_busy`=1 is dropped and sets `io_err`=1.
  - `io_rd` and `io_wr` together count as a write.
- **Eligibility:**
  - SIE is eligible when `sie_req`=1 and `sie_ack`=0. The request is consumed during the ack cycle; the SIE drops `sie_req` on the edge that samples `sie_ack`.
  - CPU is eligible when `cpu_pend`=1 (registered, from an earlier edge).
- **Arbitration:**
  - Combinational, one grant per edge.
  - Only one eligible requester: it wins.
  - Both eligible: round-robin against `last_grant`; the requester not granted last wins.
- **FSM over `last_grant` and grant:**
  - States: IDLE, SIE_GNT, CPU_GNT.
  - IDLE→SIE_GNT or CPU_GNT on an eligible request.
  - SIE_GNT→CPU_GNT if `cpu_pend`, else IDLE (the SIE cannot re-request in its ack cycle).
  - CPU_GNT→SIE_GNT if the SIE is eligible, else IDLE.
- **RAM access:** performed on the granting edge. The RAM is synchronous, with read data registered on that edge.
- **SIE grant:** `sie_ack`=1 for exactly the following cycle. On a read, `sie_rdata` is RAM[addr] during that cycle.
- **CPU grant:** `cpu_pend`←0 and `io_busy`←0. On a read, `io_rdata` is updated.
- **Reset (asynchronous, `reset`=0):**
  - `sie_ack`=0, `sie_rdata`=0, `io_rdata`=0, `io_busy`=0, `io_err`=0.
  - Pending request cleared; state IDLE; `last_grant`=CPU, so the SIE wins the first tie.
  - RAM contents are not reset.
  - A reset mid-transaction aborts the pending CPU op; no write is performed.

## Timing
- **SIE:** `sie_req` sampled at edge E while granted → `sie_ack`=1 and data valid in cycle E..E+1. Worst-case wait is one extra edge, when the CPU wins a tie.
- **CPU:**
  - Strobe at edge E0 → `io_busy`=1 after E0.
  - Uncontended: grant at E0+1, `io_busy`=0 and `io_rdata` valid after E0+1.
  - Contended: completes by E0+2.
- **Same-edge events:** an SIE request and a new CPU strobe at the same edge → SIE granted; the CPU strobe is only captured.
- **Throughput:** back-to-back SIE requests are spaced ≥2 edges. This is guaranteed by the low-speed byte rate of ≥128 clk.
- `io_busy` rises the cycle after the strobe. The J1 polls `io_busy` or inserts one wait state.

## Test plan
- SIE writes 8'hA5 to address 3 with no CPU traffic → `sie_ack` high for exactly 1 cycle, one edge after `sie_req`. A CPU read of 16'h0103 → `io_busy` high 1 cycle, then `io_rdata`=8'hA5.
- CPU writes 16'h005A to 16'h013F, then SIE reads address 63 → `sie_rdata`=8'h5A during `sie_ack`.
- Both eligible at the same edge after reset → SIE granted first, CPU next edge. Repeat with `last_grant`=SIE → CPU granted first. `io_busy` never exceeds 2 cycles.
- Second CPU strobe while `io_busy`=1 → ignored, RAM unchanged, `io_err`=1 until reset. A strobe to 16'h0200 (outside the window) → no `io_busy`.
- `reset` asserted while `cpu_pend`=1 for a write of 8'hFF to address 0 → all outputs 0 immediately, no `clk` needed. After release, a read of address 0 returns its prior value.
- 1000 random cycles of SIE requests at a 128-clk byte rate plus random CPU accesses, checked against a reference memory model → no mismatch, no lost request, every `sie_ack` within 2 edges.

Source files
------------

// File: rtl/usb_buffer_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : usb_buffer_arbiter_if
//  Brief    : SIE byte port and J1 I/O bus bundle for the packet buffer arbiter
//  Revision : 1.0
// ============================================================================
interface usb_buffer_arbiter_if #(
    parameter int AW = 6
) ();
    logic          sie_req;
    logic          sie_we;
    logic [AW-1:0] sie_addr;
    logic [7:0]    sie_wdata;
    logic          sie_ack;
    logic [7:0]    sie_rdata;

    logic [15:0]   io_addr;
    logic [15:0]   io_dout;
    logic          io_rd;
    logic          io_wr;
    logic [7:0]    io_rdata;
    logic          io_busy;
    logic          io_err;

    // master: SIE + J1 side; slave: the arbiter that owns the RAM
    modport master (
        output sie_req, sie_we, sie_addr, sie_wdata, io_addr, io_dout, io_rd, io_wr,
        input  sie_ack, sie_rdata, io_rdata, io_busy, io_err
    );

    modport slave (
        input  sie_req, sie_we, sie_addr, sie_wdata, io_addr, io_dout, io_rd, io_wr,
        output sie_ack, sie_rdata, io_rdata, io_busy, io_err
    );
endinterface
`default_nettype wire

// File: rtl/usb_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : usb_buffer_arbiter
//  Brief    : Shares the single-port USB packet buffer between SIE and J1 CPU
//  Revision : 1.0
// ============================================================================
module usb_buffer_arbiter #(
    parameter int          DEPTH     = 64,
    parameter logic [15:0] BASE_ADDR = 16'h0100
) (
    input wire                  clk,
    input wire                  reset,
    usb_buffer_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [15-AW:0] c_win_tag = BASE_ADDR[15:AW];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SIE_GNT = 2'd1,
        ST_CPU_GNT = 2'd2
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last_cpu;
    logic          r_cpu_pend;
    logic          r_cpu_we;
    logic [AW-1:0] r_cpu_addr;
    logic [7:0]    r_cpu_wdata;
    logic [7:0]    r_sie_rdata;
    logic [7:0]    r_io_rdata;
    logic          r_io_err;

    logic          w_hit;
    logic          w_sie_elig;
    logic          w_cpu_elig;
    logic          w_sie_gnt;
    logic          w_cpu_gnt;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [7:0]    w_mem_wdata;
    logic          w_unused;

    assign w_unused   = ^bus.io_dout[15:8];
    assign w_hit      = (bus.io_rd | bus.io_wr) && (bus.io_addr[15:AW] == c_win_tag);
    // The SIE holds sie_req through its ack cycle, so it is not a new request then
    assign w_sie_elig = bus.sie_req && (r_state != ST_SIE_GNT);
    assign w_cpu_elig = r_cpu_pend;

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_SIE_GNT: w_state_nxt = w_cpu_elig ? ST_CPU_GNT : ST_IDLE;
            ST_CPU_GNT: w_state_nxt = w_sie_elig ? ST_SIE_GNT : ST_IDLE;
            default: begin
                if (w_sie_elig && (!w_cpu_elig || r_last_cpu))
                    w_state_nxt = ST_SIE_GNT;
                else if (w_cpu_elig)
                    w_state_nxt = ST_CPU_GNT;
            end
        endcase
    end

    assign w_sie_gnt = (w_state_nxt == ST_SIE_GNT);
    assign w_cpu_gnt = (w_state_nxt == ST_CPU_GNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last_cpu  <= 1'b1;
            r_cpu_pend  <= 1'b0;
            r_cpu_we    <= 1'b0;
            r_cpu_addr  <= '0;
            r_cpu_wdata <= 8'h00;
            r_sie_rdata <= 8'h00;
            r_io_rdata  <= 8'h00;
            r_io_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sie_gnt) begin
                r_last_cpu <= 1'b0;
                if (!bus.sie_we)
                    r_sie_rdata <= r_mem[bus.sie_addr];
            end
            if (w_cpu_gnt) begin
                r_last_cpu <= 1'b1;
                r_cpu_pend <= 1'b0;
                if (!r_cpu_we)
                    r_io_rdata <= r_mem[r_cpu_addr];
            end
            // Capture and grant are exclusive: a grant needs cpu_pend, a capture needs it clear
            if (w_hit) begin
                if (r_cpu_pend) begin
                    r_io_err <= 1'b1;
                end else begin
                    r_cpu_pend  <= 1'b1;
                    r_cpu_we    <= bus.io_wr;
                    r_cpu_addr  <= bus.io_addr[AW-1:0];
                    r_cpu_wdata <= bus.io_dout[7:0];
                end
            end
        end
    end

    // Writes are gated by reset so an aborted pending op never reaches the RAM
    assign w_mem_we    = reset && ((w_sie_gnt && bus.sie_we) || (w_cpu_gnt && r_cpu_we));
    assign w_mem_addr  = w_sie_gnt ? bus.sie_addr  : r_cpu_addr;
    assign w_mem_wdata = w_sie_gnt ? bus.sie_wdata : r_cpu_wdata;

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_wdata;
    end

    assign bus.sie_ack   = (r_state == ST_SIE_GNT);
    assign bus.sie_rdata = r_sie_rdata;
    assign bus.io_rdata  = r_io_rdata;
    assign bus.io_busy   = r_cpu_pend;
    assign bus.io_err    = r_io_err;
endmodule
`default_nettype wire

// File: tb/tb_usb_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_buffer_arbiter
//  Brief    : Directed and randomized bench for usb_buffer_arbiter
//  Revision : 1.0
// ============================================================================
module tb_usb_buffer_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usb_buffer_arbiter_if #(.AW(6)) bus ();

    usb_buffer_arbiter #(.DEPTH(64), .BASE_ADDR(16'h0100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  ref_mem [64];
    int          lat, alen, sie_age, c_age, sie_gap, op, sel;
    logic [7:0]  rd, s_data, c_data;
    logic [5:0]  s_addr, c_addr;
    bit          sie_out, cpu_out, ack_prev, sie_done, cpu_done, s_we, c_we, c_hit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One CPU strobe; lat = extra edges io_busy stayed high after the capture edge
    task automatic cpu_op(input logic wr, input logic [15:0] addr, input logic [7:0] d,
                          output int l);
        bus.io_addr = addr;
        bus.io_dout = {8'h00, d};
        bus.io_wr   = wr;
        bus.io_rd   = !wr;
        @(negedge clk);
        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
        l = 0;
        while (bus.io_busy && l < 4) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic sie_op(input logic we, input logic [5:0] a, input logic [7:0] d,
                          output int l, output int alen_o, output logic [7:0] rdat);
        bus.sie_req   = 1'b1;
        bus.sie_we    = we;
        bus.sie_addr  = a;
        bus.sie_wdata = d;
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!bus.sie_ack && l < 4);
        rdat        = bus.sie_rdata;
        bus.sie_req = 1'b0;
        alen_o      = 0;
        while (bus.sie_ack && alen_o < 4) begin
            alen_o++;
            @(negedge clk);
        end
    endtask

    // CPU read of x is captured one edge before the SIE read of y, so both contend together
    task automatic tie_test(input bit cpu_first, input logic [5:0] x, input logic [5:0] y);
        bus.io_addr = 16'h0100 + 16'(x);
        bus.io_rd   = 1'b1;
        @(negedge clk);
        bus.io_rd = 1'b0;
        chk("tie_busy_rise", bus.io_busy, 1);
        bus.sie_req  = 1'b1;
        bus.sie_we   = 1'b0;
        bus.sie_addr = y;
        @(negedge clk);
        if (cpu_first) begin
            chk("tie_cpu_first_busy", bus.io_busy, 0);
            chk("tie_cpu_first_ack", bus.sie_ack, 0);
            chk("tie_cpu_first_rdata", bus.io_rdata, ref_mem[x]);
            @(negedge clk);
            chk("tie_sie_second_ack", bus.sie_ack, 1);
            chk("tie_sie_second_rdata", bus.sie_rdata, ref_mem[y]);
            bus.sie_req = 1'b0;
        end else begin
            chk("tie_sie_first_ack", bus.sie_ack, 1);
            chk("tie_sie_first_busy", bus.io_busy, 1);
            chk("tie_sie_first_rdata", bus.sie_rdata, ref_mem[y]);
            bus.sie_req = 1'b0;
            @(negedge clk);
            chk("tie_cpu_second_busy", bus.io_busy, 0);
            chk("tie_cpu_second_rdata", bus.io_rdata, ref_mem[x]);
        end
        @(negedge clk);
        chk("tie_ack_drop", bus.sie_ack, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.sie_req = 1'b0; bus.sie_we = 1'b0; bus.sie_addr = '0; bus.sie_wdata = 8'h00;
        bus.io_addr = 16'h0000; bus.io_dout = 16'h0000; bus.io_rd = 1'b0; bus.io_wr = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_sie_ack", bus.sie_ack, 0);
        chk("rst_sie_rdata", bus.sie_rdata, 0);
        chk("rst_io_rdata", bus.io_rdata, 0);
        chk("rst_io_busy", bus.io_busy, 0);
        chk("rst_io_err", bus.io_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'(i * 37 + 3);
            cpu_op(1'b1, 16'h0100 + 16'(i), ref_mem[i], lat);
        end

        sie_op(1'b1, 6'd3, 8'hA5, lat, alen, rd);
        ref_mem[3] = 8'hA5;
        chk("sie_wr_latency", lat, 1);
        chk("sie_wr_ack_len", alen, 1);
        cpu_op(1'b0, 16'h0103, 8'h00, lat);
        chk("cpu_rd_busy_len", lat, 1);
        chk("cpu_rd_data", bus.io_rdata, 8'hA5);

        cpu_op(1'b1, 16'h013F, 8'h5A, lat);
        ref_mem[63] = 8'h5A;
        chk("cpu_wr_busy_len", lat, 1);
        sie_op(1'b0, 6'd63, 8'h00, lat, alen, rd);
        chk("sie_rd_latency", lat, 1);
        chk("sie_rd_ack_len", alen, 1);
        chk("sie_rd_data", rd, 8'h5A);

        tie_test(1'b1, 6'd10, 6'd20);
        cpu_op(1'b0, 16'h0107, 8'h00, lat);
        chk("cpu_rd7_data", bus.io_rdata, ref_mem[7]);
        tie_test(1'b0, 6'd30, 6'd40);

        // Second strobe arrives while the first is still pending
        bus.io_addr = 16'h0105; bus.io_dout = 16'h0011; bus.io_wr = 1'b1;
        @(negedge clk);
        chk("err_busy", bus.io_busy, 1);
        chk("err_before", bus.io_err, 0);
        bus.io_addr = 16'h0106; bus.io_dout = 16'h0077;
        @(negedge clk);
        bus.io_wr = 1'b0;
        ref_mem[5] = 8'h11;
        chk("err_set", bus.io_err, 1);
        chk("err_busy_done", bus.io_busy, 0);
        cpu_op(1'b0, 16'h0106, 8'h00, lat);
        chk("err_dropped_wr", bus.io_rdata, ref_mem[6]);
        cpu_op(1'b0, 16'h0105, 8'h00, lat);
        chk("err_first_wr", bus.io_rdata, 8'h11);
        chk("err_sticky", bus.io_err, 1);

        cpu_op(1'b0, 16'h0200, 8'h00, lat);
        chk("oow_0200", lat, 0);
        cpu_op(1'b1, 16'h0140, 8'hEE, lat);
        chk("oow_0140", lat, 0);
        cpu_op(1'b1, 16'h00FF, 8'hEE, lat);
        chk("oow_00ff", lat, 0);

        bus.io_addr = 16'h0100; bus.io_dout = 16'h00FF; bus.io_wr = 1'b1;
        @(negedge clk);
        bus.io_wr = 1'b0;
        chk("rst_pend_busy", bus.io_busy, 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_sie_ack", bus.sie_ack, 0);
        chk("arst_sie_rdata", bus.sie_rdata, 0);
        chk("arst_io_rdata", bus.io_rdata, 0);
        chk("arst_io_busy", bus.io_busy, 0);
        chk("arst_io_err", bus.io_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tie_test(1'b0, 6'd0, 6'd1);

        sie_out = 0; cpu_out = 0; ack_prev = 0; sie_gap = 3; sie_age = 0; c_age = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            sie_done = 0;
            cpu_done = 0;
            if (sie_out) begin
                sie_age++;
                if (bus.sie_ack) begin
                    sie_done = 1;
                    if (s_we) ref_mem[s_addr] = s_data;
                    else      chk("rnd_sie_rdata", bus.sie_rdata, ref_mem[s_addr]);
                    bus.sie_req = 1'b0;
                    sie_out     = 0;
                    ack_prev    = 1;
                end else begin
                    chk("rnd_sie_wait", sie_age < 2, 1);
                    if (sie_age >= 2) begin
                        bus.sie_req = 1'b0;
                        sie_out     = 0;
                    end
                end
            end else begin
                if (ack_prev || bus.sie_ack) chk("rnd_sie_ack_len", bus.sie_ack, 0);
                ack_prev = 0;
            end

            if (cpu_out) begin
                if (c_age == 0) begin
                    chk("rnd_busy_rise", bus.io_busy, c_hit);
                    c_age = 1;
                    if (!c_hit || !bus.io_busy) cpu_out = 0;
                end else if (!bus.io_busy) begin
                    cpu_done = 1;
                    if (c_we) ref_mem[c_addr] = c_data;
                    else      chk("rnd_io_rdata", bus.io_rdata, ref_mem[c_addr]);
                    cpu_out = 0;
                end else begin
                    chk("rnd_busy_len", c_age < 2, 1);
                    c_age++;
                    if (c_age > 2) cpu_out = 0;
                end
            end
            if (sie_done || cpu_done) chk("rnd_one_grant", sie_done && cpu_done, 0);

            bus.io_rd = 1'b0;
            bus.io_wr = 1'b0;
            if (cyc < 980) begin
                if (!sie_out) begin
                    sie_gap--;
                    if (sie_gap <= 0) begin
                        s_we   = 1'($urandom_range(0, 1));
                        s_addr = 6'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 63));
                        s_data = 8'($urandom);
                        bus.sie_req = 1'b1; bus.sie_we = s_we;
                        bus.sie_addr = s_addr; bus.sie_wdata = s_data;
                        sie_out = 1; sie_age = 0; sie_gap = 128;
                    end
                end
                if (!cpu_out && !bus.io_busy && $urandom_range(0, 2) == 0) begin
                    sel    = int'($urandom_range(0, 7));
                    op     = int'($urandom_range(0, 3));
                    c_addr = 6'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 63));
                    c_data = 8'($urandom);
                    c_hit  = (sel != 0);
                    c_we   = (op >= 2);
                    bus.io_addr = c_hit ? 16'h0100 + 16'(c_addr)
                                        : ($urandom_range(0, 1) != 0 ? 16'h0140 : 16'h00C0) + 16'(c_addr);
                    bus.io_dout = {8'($urandom), c_data};
                    bus.io_rd   = (op != 2);
                    bus.io_wr   = (op >= 2);
                    cpu_out = 1;
                    c_age   = 0;
                end
            end
        end
        chk("rnd_no_err", bus.io_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
